// File: rtl/memctrl_arb_pkg.sv
// Shared types and constants for the memctrl_arb two-requester MEMCTRL sequencer.
package memctrl_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // Deasserted levels of the MEMCTRL strobes
  localparam logic CE_IDLE  = 1'b0;
  localparam logic CSB_IDLE = 1'b1;
  localparam logic WEB_IDLE = 1'b1;
  localparam logic OEB_IDLE = 1'b1;

  localparam int RD_LAT_MAX = 4;
  localparam int CNT_W      = $clog2(RD_LAT_MAX + 1);

endpackage

// File: rtl/memctrl_arb_rr.sv
// 2-way round-robin picker; MEMCTRL_ARB_FIXED_PRIO_EN selects strict priority to requester 0.
module memctrl_arb_rr (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] winner
);

`ifdef MEMCTRL_ARB_FIXED_PRIO_EN
  logic unused_ok;
  assign unused_ok = ^{clk, rst, update};

  always_comb begin
    winner = 2'b00;
    if (req[0])      winner = 2'b01;
    else if (req[1]) winner = 2'b10;
  end
`else
  // Set when requester 1 won last, so requester 0 takes the next tie
  logic last1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last1 <= 1'b1;
    else if (update) last1 <= winner[1];
  end

  always_comb begin
    winner = 2'b00;
    case (req)
      2'b01:   winner = 2'b01;
      2'b10:   winner = 2'b10;
      2'b11:   winner = last1 ? 2'b01 : 2'b10;
      default: winner = 2'b00;
    endcase
  end
`endif

endmodule

// File: rtl/memctrl_arb.sv
// Two-requester arbiter/sequencer driving MEMCTRL strobes (one active cycle, then HOLD).
// Build option: MEMCTRL_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module memctrl_arb
  import memctrl_arb_pkg::*;
#(
  parameter int AW     = 16,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          REQ0,
  input  logic          WE0,
  input  logic [AW-1:0] ADDR0,
  input  logic [DW-1:0] WDATA0,
  output logic          GNT0,
  output logic          RVALID0,
  output logic [DW-1:0] RDATA0,
  input  logic          REQ1,
  input  logic          WE1,
  input  logic [AW-1:0] ADDR1,
  input  logic [DW-1:0] WDATA1,
  output logic          GNT1,
  output logic          RVALID1,
  output logic [DW-1:0] RDATA1,
  output logic          MEM_CE,
  output logic          MEM_CSB,
  output logic          MEM_WEB,
  output logic          MEM_OEB,
  output logic [AW-1:0] MEM_ADDR,
  output logic [DW-1:0] MEM_IDATA,
  input  logic [DW-1:0] MEM_ODATA,
  output state_t        DBG_STATE
);

  // Handshake: GNTx pulses for one cycle while REQx is still held; the
  // requester's WE/ADDR/WDATA are captured at the edge ending that cycle.

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             owner_q, owner_d;
  logic             we_q, we_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       rvalid_q, rvalid_d;
  logic [DW-1:0]    rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic             ce_q, ce_d, csb_q, csb_d, web_q, web_d, oeb_q, oeb_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    idata_q, idata_d;

  logic [1:0]       win;
  logic             grant_slot;
  logic             rr_update;
  logic             sel_we;
  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    sel_wdata;

  // A grant may be issued from an empty IDLE or on the final HOLD cycle,
  // so the granted cycle coincides with the return to IDLE.
  assign grant_slot = ((state_q == IDLE) && (gnt_q == 2'b00)) ||
                      ((state_q == HOLD) && (cnt_q == CNT_W'(1)));
  assign rr_update  = grant_slot && (win != 2'b00);

  assign sel_we    = gnt_q[1] ? WE1    : WE0;
  assign sel_addr  = gnt_q[1] ? ADDR1  : ADDR0;
  assign sel_wdata = gnt_q[1] ? WDATA1 : WDATA0;

  memctrl_arb_rr u_rr (
    .clk    (CLK),
    .rst    (RST),
    .req    ({REQ1, REQ0}),
    .update (rr_update),
    .winner (win)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    we_d     = we_q;
    gnt_d    = 2'b00;
    rvalid_d = 2'b00;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    ce_d     = CE_IDLE;
    csb_d    = CSB_IDLE;
    web_d    = WEB_IDLE;
    oeb_d    = OEB_IDLE;
    addr_d   = addr_q;
    idata_d  = '0;
    if (rr_update) gnt_d = win;
    case (state_q)
      IDLE: begin
        if (gnt_q != 2'b00) begin
          owner_d = gnt_q[1];
          we_d    = sel_we;
          ce_d    = 1'b1;
          csb_d   = 1'b0;
          addr_d  = sel_addr;
          if (sel_we) begin
            web_d   = 1'b0;
            idata_d = sel_wdata;
          end else begin
            oeb_d   = 1'b0;
          end
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        state_d = HOLD;
        cnt_d   = we_q ? CNT_W'(1) : CNT_W'(RD_LAT);
      end
      HOLD: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          if (!we_q) begin
            if (owner_q) begin
              rvalid_d = 2'b10;
              rdata1_d = MEM_ODATA;
            end else begin
              rvalid_d = 2'b01;
              rdata0_d = MEM_ODATA;
            end
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      gnt_q    <= 2'b00;
      rvalid_q <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
      ce_q     <= CE_IDLE;
      csb_q    <= CSB_IDLE;
      web_q    <= WEB_IDLE;
      oeb_q    <= OEB_IDLE;
      addr_q   <= '0;
      idata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      ce_q     <= ce_d;
      csb_q    <= csb_d;
      web_q    <= web_d;
      oeb_q    <= oeb_d;
      addr_q   <= addr_d;
      idata_q  <= idata_d;
    end
  end

  assign GNT0      = gnt_q[0];
  assign GNT1      = gnt_q[1];
  assign RVALID0   = rvalid_q[0];
  assign RVALID1   = rvalid_q[1];
  assign RDATA0    = rdata0_q;
  assign RDATA1    = rdata1_q;
  assign MEM_CE    = ce_q;
  assign MEM_CSB   = csb_q;
  assign MEM_WEB   = web_q;
  assign MEM_OEB   = oeb_q;
  assign MEM_ADDR  = addr_q;
  assign MEM_IDATA = idata_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_memctrl_arb.sv
// Scoreboard bench for memctrl_arb: dut0 uses RD_LAT=1, dut1 uses RD_LAT=4 for the 0xFFFF read.
module tb_memctrl_arb;
  import memctrl_arb_pkg::*;

  localparam int RD_LAT0 = 1;
  localparam int RD_LAT1 = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- dut0 ----------------
  logic        req0, we0, req1, we1;
  logic [15:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0]  rdata0, rdata1;
  logic        mem_ce, mem_csb, mem_web, mem_oeb;
  logic [15:0] mem_addr;
  logic [7:0]  mem_idata, mem_odata;
  state_t      dbg_state;

  memctrl_arb #(.AW(16), .DW(8), .RD_LAT(RD_LAT0)) dut0 (
    .CLK(clk), .RST(rst),
    .REQ0(req0), .WE0(we0), .ADDR0(addr0), .WDATA0(wdata0),
    .GNT0(gnt0), .RVALID0(rvalid0), .RDATA0(rdata0),
    .REQ1(req1), .WE1(we1), .ADDR1(addr1), .WDATA1(wdata1),
    .GNT1(gnt1), .RVALID1(rvalid1), .RDATA1(rdata1),
    .MEM_CE(mem_ce), .MEM_CSB(mem_csb), .MEM_WEB(mem_web), .MEM_OEB(mem_oeb),
    .MEM_ADDR(mem_addr), .MEM_IDATA(mem_idata), .MEM_ODATA(mem_odata),
    .DBG_STATE(dbg_state)
  );

  // MEMCTRL model for dut0: ODATA valid exactly one cycle after the read strobe
  logic [7:0] mem0 [0:65535];
  always @(posedge clk) begin
    if (mem_ce && !mem_csb && !mem_web) mem0[mem_addr] <= mem_idata;
    mem_odata <= (mem_ce && !mem_csb && !mem_oeb) ? mem0[mem_addr] : 8'h00;
  end

  // ---------------- dut1 ----------------
  logic        b_req0, b_we0;
  logic [15:0] b_addr0;
  logic        b_gnt0, b_gnt1, b_rvalid0, b_rvalid1;
  logic [7:0]  b_rdata0, b_rdata1;
  logic        b_mem_ce, b_mem_csb, b_mem_web, b_mem_oeb;
  logic [15:0] b_mem_addr;
  logic [7:0]  b_mem_idata, b_mem_odata;
  state_t      b_dbg_state;
  logic [7:0]  b_pipe [4];

  memctrl_arb #(.AW(16), .DW(8), .RD_LAT(RD_LAT1)) dut1 (
    .CLK(clk), .RST(rst),
    .REQ0(b_req0), .WE0(b_we0), .ADDR0(b_addr0), .WDATA0(8'h00),
    .GNT0(b_gnt0), .RVALID0(b_rvalid0), .RDATA0(b_rdata0),
    .REQ1(1'b0), .WE1(1'b0), .ADDR1(16'h0000), .WDATA1(8'h00),
    .GNT1(b_gnt1), .RVALID1(b_rvalid1), .RDATA1(b_rdata1),
    .MEM_CE(b_mem_ce), .MEM_CSB(b_mem_csb), .MEM_WEB(b_mem_web), .MEM_OEB(b_mem_oeb),
    .MEM_ADDR(b_mem_addr), .MEM_IDATA(b_mem_idata), .MEM_ODATA(b_mem_odata),
    .DBG_STATE(b_dbg_state)
  );

  // MEMCTRL model for dut1: 4-cycle read latency, only 0xFFFF holds data
  always @(posedge clk) begin
    b_pipe[0] <= (b_mem_ce && !b_mem_csb && !b_mem_oeb && b_mem_addr == 16'hFFFF) ? 8'h3C : 8'h00;
    for (int i = 1; i < 4; i++) b_pipe[i] <= b_pipe[i-1];
  end
  assign b_mem_odata = b_pipe[3];

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0]  exp_gnt_q[$];
  logic [25:0] exp_mem_q[$];   // {web, oeb, addr, idata}
  logic [8:0]  exp_rd_q[$];    // {port, data}
  logic [1:0]  exp_gnt1_q[$];
  logic [8:0]  exp_rd1_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event not matched by expectation (cycle %0d)", name, cyc);
  endtask

  // ---------------- monitors ----------------
  int         last_gnt = -100;
  logic [1:0]  e_gnt;
  logic [25:0] e_mem;
  logic [8:0]  e_rd;

  always @(negedge clk) begin
    if (!rst) begin
      if (rvalid0 || rvalid1) begin
        check("rvalid_exclusive", {31'd0, rvalid0 & rvalid1}, 32'd0);
        if (exp_rd_q.size() == 0) fail_now("unexpected_rvalid");
        else begin
          e_rd = exp_rd_q.pop_front();
          check("rd_port_data", {rvalid1, rvalid1 ? rdata1 : rdata0}, e_rd);
          check("rd_latency", cyc - last_gnt, 2 + RD_LAT0);
        end
      end
      if (mem_ce) begin
        if (exp_mem_q.size() == 0) fail_now("unexpected_strobe");
        else begin
          e_mem = exp_mem_q.pop_front();
          check("mem_strobe", {mem_csb, mem_web, mem_oeb, mem_addr, mem_idata}, {1'b0, e_mem});
          check("strobe_latency", cyc - last_gnt, 1);
        end
      end
      if (cyc == last_gnt + 2)
        check("strobe_idle", {mem_ce, mem_csb, mem_web, mem_oeb, mem_idata}, {1'b0, 1'b1, 1'b1, 1'b1, 8'h00});
      if (gnt0 || gnt1) begin
        if (exp_gnt_q.size() == 0) fail_now("unexpected_grant");
        else begin
          e_gnt = exp_gnt_q.pop_front();
          check("grant", {gnt1, gnt0}, e_gnt);
        end
        last_gnt = cyc;
      end
    end
  end

  int         b_last_gnt = -100;
  logic [1:0] e_gnt1;
  logic [8:0] e_rd1;

  always @(negedge clk) begin
    if (!rst) begin
      if (b_rvalid0 || b_rvalid1) begin
        if (exp_rd1_q.size() == 0) fail_now("b_unexpected_rvalid");
        else begin
          e_rd1 = exp_rd1_q.pop_front();
          check("b_rd_port_data", {b_rvalid1, b_rvalid1 ? b_rdata1 : b_rdata0}, e_rd1);
          check("b_rd_latency", cyc - b_last_gnt, 2 + RD_LAT1);
        end
      end
      if (b_gnt0 || b_gnt1) begin
        if (exp_gnt1_q.size() == 0) fail_now("b_unexpected_grant");
        else begin
          e_gnt1 = exp_gnt1_q.pop_front();
          check("b_grant", {b_gnt1, b_gnt0}, e_gnt1);
        end
        b_last_gnt = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_gnt(input bit p, output int gcyc);
    bit got;
    got  = 1'b0;
    gcyc = -1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (p ? gnt1 : gnt0) begin
        got  = 1'b1;
        gcyc = cyc;
      end
    end
    if (!got) fail_now("gnt_timeout");
  endtask

  task automatic single(input bit p, input bit we, input logic [15:0] a, input logic [7:0] d);
    int g;
    if (p) begin we1 = we; addr1 = a; wdata1 = d; req1 = 1'b1; end
    else   begin we0 = we; addr0 = a; wdata0 = d; req0 = 1'b1; end
    wait_gnt(p, g);
    @(posedge clk); #1;
    if (p) req1 = 1'b0; else req0 = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  int g_lone [3];
  int g, n;

  initial begin
    rst = 1'b1;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    b_req0 = 0; b_we0 = 0; b_addr0 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_strobes", {mem_ce, mem_csb, mem_web, mem_oeb}, 4'b0111);
    check("rst_addr_idata", {mem_addr, mem_idata}, 24'h0);
    check("rst_outputs", {gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1}, 20'h0);
    check("rst_state", dbg_state, IDLE);
    rst = 1'b0;
    @(posedge clk); #1;

    // single write from requester 0
    exp_gnt_q.push_back(2'b01);
    exp_mem_q.push_back({1'b0, 1'b1, 16'h0010, 8'hA5});
    single(1'b0, 1'b1, 16'h0010, 8'hA5);

    // read-back by requester 1; WDATA1 must not leak onto IDATA
    exp_gnt_q.push_back(2'b10);
    exp_mem_q.push_back({1'b1, 1'b0, 16'h0010, 8'h00});
    exp_rd_q.push_back({1'b1, 8'hA5});
    single(1'b1, 1'b0, 16'h0010, 8'h77);

    // tie held across four accesses
    for (int i = 0; i < 4; i++) begin
`ifdef MEMCTRL_ARB_FIXED_PRIO_EN
      exp_gnt_q.push_back(2'b01);
      exp_mem_q.push_back({1'b0, 1'b1, 16'h0100, 8'h11});
`else
      exp_gnt_q.push_back((i % 2 == 0) ? 2'b01 : 2'b10);
      exp_mem_q.push_back((i % 2 == 0) ? {1'b0, 1'b1, 16'h0100, 8'h11} : {1'b0, 1'b1, 16'h0200, 8'h22});
`endif
    end
    we0 = 1; addr0 = 16'h0100; wdata0 = 8'h11;
    we1 = 1; addr1 = 16'h0200; wdata1 = 8'h22;
    req0 = 1; req1 = 1;
    n = 0;
    for (int i = 0; i < 60 && n < 4; i++) begin
      @(negedge clk);
      if (gnt0 || gnt1) n++;
    end
    if (n < 4) fail_now("tie_timeout");
    @(posedge clk); #1;
    req0 = 0; req1 = 0;
    repeat (6) @(posedge clk);
    #1;

    // lone requester, three back-to-back writes
    for (int i = 0; i < 3; i++) begin
      exp_gnt_q.push_back(2'b01);
      exp_mem_q.push_back({1'b0, 1'b1, 16'h0020 + 16'(i), 8'h31 + 8'(i)});
    end
    we0 = 1; addr0 = 16'h0020; wdata0 = 8'h31; req0 = 1;
    for (int i = 0; i < 3; i++) begin
      wait_gnt(1'b0, g_lone[i]);
      @(posedge clk); #1;
      if (i < 2) begin
        addr0  = 16'h0020 + 16'(i + 1);
        wdata0 = 8'h31 + 8'(i + 1);
      end else begin
        req0 = 0;
      end
    end
    check("lone_spacing_1", g_lone[1] - g_lone[0], 3);
    check("lone_spacing_2", g_lone[2] - g_lone[1], 3);
    repeat (6) @(posedge clk);
    #1;
    check("rdata1_hold", rdata1, 8'hA5);
    check("rdata0_untouched", rdata0, 8'h00);

    // reset during the HOLD of a read: the access is abandoned
    exp_gnt_q.push_back(2'b01);
    exp_mem_q.push_back({1'b1, 1'b0, 16'h0010, 8'h00});
    we0 = 0; addr0 = 16'h0010; req0 = 1;
    wait_gnt(1'b0, g);
    @(posedge clk); #1;
    req0 = 0;
    @(posedge clk); #2;
    check("pre_rst_state", dbg_state, HOLD);
    rst = 1'b1;
    #1;
    check("mid_rst_state", dbg_state, IDLE);
    check("mid_rst_strobes", {mem_ce, mem_csb, mem_web, mem_oeb, mem_idata}, {1'b0, 1'b1, 1'b1, 1'b1, 8'h00});
    check("mid_rst_outputs", {gnt0, gnt1, rvalid0, rvalid1}, 4'b0000);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // first tie after reset goes to requester 0
    exp_gnt_q.push_back(2'b01);
    exp_mem_q.push_back({1'b0, 1'b1, 16'h0030, 8'h5A});
    we0 = 1; addr0 = 16'h0030; wdata0 = 8'h5A;
    we1 = 1; addr1 = 16'h0040; wdata1 = 8'h6B;
    req0 = 1; req1 = 1;
    wait_gnt(1'b0, g);
    @(posedge clk); #1;
    req0 = 0; req1 = 0;
    repeat (6) @(posedge clk);
    #1;

    // 0xFFFF read with RD_LAT=4, request held throughout
    exp_gnt1_q.push_back(2'b01);
    exp_gnt1_q.push_back(2'b01);
    exp_rd1_q.push_back({1'b0, 8'h3C});
    exp_rd1_q.push_back({1'b0, 8'h3C});
    b_we0 = 0; b_addr0 = 16'hFFFF; b_req0 = 1;
    g = -1;
    for (int i = 0; i < 40 && g < 0; i++) begin
      @(negedge clk);
      if (b_gnt0) g = cyc;
    end
    if (g < 0) fail_now("b_gnt_timeout");
    n = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1)
        check("b_strobe", {b_mem_ce, b_mem_csb, b_mem_web, b_mem_oeb, b_mem_addr}, {1'b1, 1'b0, 1'b1, 1'b0, 16'hFFFF});
      if (b_gnt0 || b_gnt1) n++;
    end
    check("b_no_grant_window", n, 0);
    @(negedge clk);
    check("b_regrant_cycle", b_gnt0 ? (cyc - g) : -1, 6);
    @(posedge clk); #1;
    b_req0 = 0;
    repeat (12) @(posedge clk);
    #1;

    check("gnt_q_drained", exp_gnt_q.size(), 0);
    check("mem_q_drained", exp_mem_q.size(), 0);
    check("rd_q_drained", exp_rd_q.size(), 0);
    check("b_gnt_q_drained", exp_gnt1_q.size(), 0);
    check("b_rd_q_drained", exp_rd1_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    fail_now("watchdog");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
